// File: rtl/vector_mem_mover_if.sv
// Command, memory and register-file bus for vector_mem_mover.
//   start/op/base_addr/reg_sel/vec_in : command from the controller
//   mem_addr/mem_wdata/mem_we/mem_rdata : 32-bit word memory port
//   rf_data/rf_sel/rf_we : 512-bit vector register-file write port
//   busy/done : status
// modport master is the mover side; modport slave is the surrounding system.
interface vector_mem_mover_if;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 16;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned VEC_W  = WORD_W * LANES;

    logic              start;
    logic              op;
    logic [ADDR_W-1:0] base_addr;
    logic [1:0]        reg_sel;
    logic [VEC_W-1:0]  vec_in;
    logic [WORD_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_we;
    logic [VEC_W-1:0]  rf_data;
    logic [1:0]        rf_sel;
    logic              rf_we;
    logic              busy;
    logic              done;

    modport master (
        input  start, op, base_addr, reg_sel, vec_in, mem_rdata,
        output mem_addr, mem_wdata, mem_we, rf_data, rf_sel, rf_we, busy, done
    );

    modport slave (
        output start, op, base_addr, reg_sel, vec_in, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, rf_data, rf_sel, rf_we, busy, done
    );
endinterface

// File: rtl/vector_mem_mover.sv
// Moves whole 512-bit vectors between 32-bit word memory and the vector
// register file. A load reads 16 consecutive words into the lanes of rf_data
// and pulses rf_we; a store writes the 16 lanes of a captured vector to 16
// consecutive words. Addresses wrap modulo 512.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears state and all outputs
//   bus   : vector_mem_mover_if.master (command, memory, register file, status)
module vector_mem_mover (
    input  logic                 clk,
    input  logic                 rst_n,
    vector_mem_mover_if.master   bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 16;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned LANE_W = 4;
    localparam int unsigned VEC_W  = WORD_W * LANES;

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_DRAIN,
        LD_COMMIT,
        ST_WRITE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          sel_q, sel_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [VEC_W-1:0]    rf_data_q, rf_data_d;
    logic [1:0]          rf_sel_q, rf_sel_d;
    logic                rf_we_q, rf_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                cap_en;
    logic [LANE_W-1:0]   cap_lane;
    logic [LANE_W-1:0]   next_lane;

    // State, command capture and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            sel_q       <= '0;
            vec_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rf_data_q   <= '0;
            rf_sel_q    <= '0;
            rf_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            sel_q       <= sel_d;
            vec_q       <= vec_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rf_data_q   <= rf_data_d;
            rf_sel_q    <= rf_sel_d;
            rf_we_q     <= rf_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state and next output values; outputs are computed one cycle
    // ahead so every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        sel_d       = sel_q;
        vec_d       = vec_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        rf_data_d   = rf_data_q;
        rf_sel_d    = rf_sel_q;
        rf_we_d     = 1'b0;
        done_d      = 1'b0;
        cap_en      = 1'b0;
        cap_lane    = '0;
        next_lane   = LANE_W'(cnt_q + CNT_W'(1));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    sel_d      = bus.reg_sel;
                    cnt_d      = '0;
                    mem_addr_d = bus.base_addr;
                    if (bus.op) begin
                        vec_d       = bus.vec_in;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.vec_in[WORD_W-1:0];
                        state_d     = ST_WRITE;
                    end else begin
                        state_d = LD_ISSUE;
                    end
                end
            end

            // Read data trails its address by one cycle, so the word on
            // mem_rdata now belongs to the previous lane.
            LD_ISSUE: begin
                if (cnt_q != '0) begin
                    cap_en   = 1'b1;
                    cap_lane = LANE_W'(cnt_q - CNT_W'(1));
                end
                if (cnt_q == CNT_W'(LANES - 1)) begin
                    state_d = LD_DRAIN;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_addr_d = base_q + ADDR_W'(cnt_q + CNT_W'(1));
                end
            end

            LD_DRAIN: begin
                cap_en   = 1'b1;
                cap_lane = LANE_W'(LANES - 1);
                rf_we_d  = 1'b1;
                done_d   = 1'b1;
                rf_sel_d = sel_q;
                state_d  = LD_COMMIT;
            end

            LD_COMMIT: begin
                state_d = IDLE;
            end

            // Counts 0..15 while writing; count 16 is the done cycle.
            ST_WRITE: begin
                if (cnt_q == CNT_W'(LANES)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(LANES - 1)) begin
                    cnt_d  = CNT_W'(LANES);
                    done_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + ADDR_W'(cnt_q + CNT_W'(1));
                    mem_wdata_d = vec_q[32'(next_lane) * WORD_W +: WORD_W];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Lanes are overwritten in place; untouched lanes keep old data.
        if (cap_en) begin
            rf_data_d[32'(cap_lane) * WORD_W +: WORD_W] = bus.mem_rdata;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.rf_sel    = rf_sel_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: doc/vector_mem_mover.md
# vector_mem_mover

Sequencer that moves whole 512-bit vectors between the 32-bit word memory and the vector register file. A load walks 16 consecutive memory words, packs them into one vector and issues a single register-file write. A store unpacks a 512-bit register-file read into 16 consecutive word writes. It sits between the memory and the register file and replaces the zero-extended single-word register writes with full-width vector loads and stores.

## Interface
- WORD_W, 32, memory word width
- LANES, 16, words per vector; vector width = WORD_W*LANES = 512
- ADDR_W, 9, memory word-address width (512 words)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  command request, sampled only in IDLE
- op  input  1  0 = load (memory to register), 1 = store (register to memory)
- base_addr  input  9  word address of lane 0
- reg_sel  input  2  target or source register index (0..3 = A1..A4)
- vec_in  input  512  store source vector, captured on the accepted start
- mem_rdata  input  32  memory read data, valid one cycle after the address
- mem_addr  output  9  memory word address
- mem_wdata  output  32  memory write data
- mem_we  output  1  memory write enable
- rf_data  output  512  assembled load vector
- rf_sel  output  2  register index for the write
- rf_we  output  1  register-file write enable, one-cycle pulse
- busy  output  1  high from the cycle after an accepted start through the done cycle
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, LD_ISSUE, LD_DRAIN, LD_COMMIT, ST_WRITE.
- IDLE:
  - If start=1, capture op, base_addr, reg_sel and (for a store) vec_in.
  - Go to LD_ISSUE if op=0, otherwise ST_WRITE. Clear the lane counter i to 0.
- LD_ISSUE:
  - mem_addr = base_addr + i, modulo 512, so addresses wrap from 511 to 0.
  - i counts 0..15. After i=15, go to LD_DRAIN.
- Load data capture:
  - mem_rdata present in the cycle after address i is written into lane i, bits [32i+31:32i] of rf_data.
  - Lanes are written in place, not shifted.
- LD_DRAIN: one cycle to capture lane 15, then go to LD_COMMIT.
- LD_COMMIT: rf_we=1, rf_sel = captured reg_sel, done=1; then go to IDLE.
- ST_WRITE:
  - mem_we=1, mem_addr = base_addr + i (modulo 512), mem_wdata = lane i of the captured vec_in.
  - i counts 0..15. After i=15, go to IDLE with done=1 in that following cycle.
- start outside IDLE is ignored; no queueing.
- Controller mode: all lane-register updates are gated by the state machine.
- mem_we=0 in every state except ST_WRITE; rf_we=0 except in LD_COMMIT.
- rf_data holds the last assembled vector until the next load overwrites its lanes.
- Reset asserted at any time:
  - Go to IDLE immediately; all outputs go to 0 (mem_addr, mem_wdata, mem_we, rf_data, rf_sel, rf_we, busy, done).
  - An interrupted load never asserts rf_we.
  - An interrupted store leaves the words already written in memory; no rollback.

## Timing
- Cycle 0 is the edge that samples start=1 in IDLE.
- Load:
  - Addresses are presented in cycles 1..16.
  - Lanes are captured at the ends of cycles 2..17.
  - rf_we and done pulse in cycle 18.
  - busy is high in cycles 1..18.
  - Latency is 18 cycles.
- Store:
  - mem_we is high in cycles 1..16; lane i is written in cycle i+1.
  - done pulses in cycle 17 with mem_we=0.
  - busy is high in cycles 1..17.
- Back-to-back: start may be held through the done cycle. The next command is accepted on the first edge in IDLE (cycle 19 for a load, 18 for a store).
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Load, base 0x010, reg_sel=2, memory word[0x010+i] = 0x100+i → addresses 0x010..0x01F in cycles 1..16; cycle 18: rf_we=1, rf_sel=2, done=1, rf_data lane i = 0x100+i.
- Store, base 0x040, vec_in lane i = 0xA5A50000+i → 16 writes, cycles 1..16, mem[0x040+i] = 0xA5A50000+i; done in cycle 17. A following load of 0x040 returns the same vector.
- Wrap-around load, base 0x1F8 → addresses 0x1F8..0x1FF then 0x000..0x007; lane 8 = mem[0x000].
- Ignored start: start pulses with op=1 in cycles 5 and 10 during a load → no mem_we, load completes unchanged in cycle 18.
- Reset mid-load: rst_n low in cycle 8 → busy=0, rf_we never asserted, all outputs 0. After release, a fresh load completes in 18 cycles with correct data.
- Reset mid-store: rst_n low in cycle 6 → exactly lanes 0..4 written, mem_we=0 from the reset onward.
